// File: rtl/imem_fetch_ctrl_if.sv
// Bundle of loader, instruction-memory and decode-facing signals of the fetch controller.
// slave is the controller's view; master is the view of the surrounding loader/memory/decode.
interface imem_fetch_ctrl_if #(
  parameter int unsigned IDX_W = 6
);
  localparam int unsigned WORD_W = 32;

  logic              load_req;
  logic              load_we;
  logic [IDX_W-1:0]  load_addr;
  logic [WORD_W-1:0] load_data;
  logic              load_done;
  logic              load_gnt;

  logic [IDX_W-1:0]  imem_addr;
  logic              imem_we;
  logic [WORD_W-1:0] imem_wdata;
  logic [WORD_W-1:0] imem_rdata;

  logic              stall;
  logic              branch_taken;
  logic [WORD_W-1:0] branch_target;
  logic [WORD_W-1:0] pc;
  logic [WORD_W-1:0] instr;
  logic              instr_valid;
  logic              fault;

  modport slave (
    input  load_req, load_we, load_addr, load_data, load_done,
    input  imem_rdata,
    input  stall, branch_taken, branch_target,
    output load_gnt,
    output imem_addr, imem_we, imem_wdata,
    output pc, instr, instr_valid, fault
  );

  modport master (
    output load_req, load_we, load_addr, load_data, load_done,
    output imem_rdata,
    output stall, branch_taken, branch_target,
    input  load_gnt,
    input  imem_addr, imem_we, imem_wdata,
    input  pc, instr, instr_valid, fault
  );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// Instruction-memory fetch controller: arbitrates the memory between the program loader and
// the fetch path, sequences the PC (fetch/branch/stall) and traps bad fetch addresses.
module imem_fetch_ctrl #(
  parameter int unsigned IDX_W    = 6,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst_n,
  imem_fetch_ctrl_if.slave bus
);
  localparam int unsigned PC_W  = 32;
  localparam int unsigned PC_WX = PC_W + 1;
  // Byte size of the memory, one bit wider so IDX_W up to 30 still fits.
  localparam logic [PC_W:0] MEM_BYTES = PC_WX'(1) << (IDX_W + 2);

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_RUN,
    ST_FAULT
  } state_e;

  state_e            r_state;
  logic [PC_W-1:0]   r_fetch_pc;
  logic [PC_W-1:0]   r_pc;
  logic [PC_W-1:0]   r_instr;
  logic              r_instr_valid;
  logic              r_fault;

  logic              w_in_load;
  logic              w_bad_fetch;

  assign w_in_load   = (r_state == ST_LOAD);
  assign w_bad_fetch = (r_fetch_pc[1:0] != 2'b00) || ({1'b0, r_fetch_pc} >= MEM_BYTES);

  // Memory port belongs to the loader in LOAD, otherwise to the fetch path (read only).
  assign bus.load_gnt   = w_in_load;
  assign bus.imem_we    = w_in_load & bus.load_we;
  assign bus.imem_addr  = w_in_load ? bus.load_addr : r_fetch_pc[IDX_W+1:2];
  assign bus.imem_wdata = w_in_load ? bus.load_data : '0;

  assign bus.pc          = r_pc;
  assign bus.instr       = r_instr;
  assign bus.instr_valid = r_instr_valid;
  assign bus.fault       = r_fault;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= ST_LOAD;
      r_fetch_pc    <= RESET_PC;
      r_pc          <= '0;
      r_instr       <= '0;
      r_instr_valid <= 1'b0;
      r_fault       <= 1'b0;
    end else begin
      case (r_state)
        ST_LOAD: begin
          r_instr_valid <= 1'b0;
          if (bus.load_done) begin
            r_state    <= ST_RUN;
            r_fetch_pc <= RESET_PC;
          end
        end

        // Priority: reload, branch, bad address, stall, sequential fetch.
        ST_RUN: begin
          if (bus.load_req) begin
            r_state       <= ST_LOAD;
            r_instr_valid <= 1'b0;
          end else if (bus.branch_taken) begin
            r_fetch_pc    <= bus.branch_target;
            r_instr_valid <= 1'b0;
          end else if (w_bad_fetch) begin
            r_state       <= ST_FAULT;
            r_fault       <= 1'b1;
            r_instr_valid <= 1'b0;
            r_pc          <= r_fetch_pc;
          end else if (!bus.stall) begin
            r_instr       <= bus.imem_rdata;
            r_pc          <= r_fetch_pc;
            r_instr_valid <= 1'b1;
            r_fetch_pc    <= r_fetch_pc + PC_W'(4);
          end
        end

        ST_FAULT: begin
          r_instr_valid <= 1'b0;
          if (bus.load_req) begin
            r_state <= ST_LOAD;
            r_fault <= 1'b0;
          end
        end

        default: begin
          r_state       <= ST_LOAD;
          r_instr_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule
